// File: rtl/silife_sched.sv
// ---------------------------------------------------------------------------
// silife_sched -- operation scheduler for the life grid core.
//
// Serialises two sources of work onto the life grid core:
//   * host operations (step / write row / read row / nop) with a
//     request-acknowledge handshake, and
//   * a periodic auto-stepper driven by a free-running period timer.
// Simultaneous requests are arbitrated round-robin. All outputs are
// registered.
//
// Ports
//   clk, rst           : system clock, synchronous active-high reset
//   host_req           : host request, held until host_ack
//   host_op            : 00 step, 01 write row, 10 read row, 11 nop
//   host_row           : row for write/read
//   host_wdata         : row data for write
//   host_ack           : one-cycle completion pulse (host operations only)
//   host_rdata         : read result, held until the next read completes
//   auto_en            : enables the auto-stepper
//   auto_period        : cycles between auto steps, 0 disables
//   life_row_select    : row address to the life grid core
//   life_wr_en         : row write strobe to the life grid core
//   life_en            : generation step strobe to the life grid core
//   life_data_in       : row write data to the life grid core
//   life_data_out      : row read data from the life grid core
//   busy               : high whenever the scheduler is not idle
//   miss_count         : (SILIFE_SCHED_STATS_EN only) saturating count of
//                        timer wraps that found an auto step still pending
//
// Build option
//   SILIFE_SCHED_STATS_EN : adds the miss_count output and its counter.
//                           Without it, overrun wraps simply merge into the
//                           single pending auto step.
// ---------------------------------------------------------------------------
module silife_sched #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_req,
  input  logic [1:0]       host_op,
  input  logic [4:0]       host_row,
  input  logic [7:0]       host_wdata,
  output logic             host_ack,
  output logic [7:0]       host_rdata,
  input  logic             auto_en,
  input  logic [CNT_W-1:0] auto_period,
  output logic [4:0]       life_row_select,
  output logic             life_wr_en,
  output logic             life_en,
  output logic [7:0]       life_data_in,
  input  logic [7:0]       life_data_out,
  output logic             busy
`ifdef SILIFE_SCHED_STATS_EN
  ,
  output logic [7:0]       miss_count
`endif
);

  localparam logic [1:0] OP_STEP  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_WRITE,
    S_RD_SETUP,
    S_RD_CAP,
    S_ACK
  } state_t;

  state_t           state_q;
  state_t           state_d;

  // auto_step_q marks the step in flight as auto-initiated (returns to IDLE
  // without an ACK). prefer_auto_q is set after a host grant so the next
  // tie goes to the auto-stepper; its reset value gives the first tie to
  // the host.
  logic             auto_step_q;
  logic             prefer_auto_q;

  logic [CNT_W-1:0] timer_q;
  logic             auto_pending_q;

  logic             auto_active;
  logic             timer_wrap;
  logic             is_idle;
  logic             grant_host;
  logic             grant_auto;

  logic             host_ack_d;
  logic             life_en_d;
  logic             life_wr_en_d;
  logic             busy_d;
  logic [4:0]       row_sel_d;
  logic [7:0]       data_in_d;
  logic [7:0]       rdata_d;

`ifdef SILIFE_SCHED_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // Timer control and arbitration
  always_comb begin
    auto_active = auto_en && (auto_period != '0);
    // >= rather than == so that shrinking the period below the current
    // count wraps on the very next cycle instead of running to overflow.
    timer_wrap  = auto_active && (timer_q >= (auto_period - CNT_W'(1)));
    is_idle     = (state_q == S_IDLE);
    grant_host  = is_idle && host_req && !(auto_pending_q && prefer_auto_q);
    grant_auto  = is_idle && auto_pending_q && !grant_host;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_host) begin
          case (host_op)
            OP_STEP:  state_d = S_STEP;
            OP_WRITE: state_d = S_WRITE;
            OP_READ:  state_d = S_RD_SETUP;
            default:  state_d = S_ACK;
          endcase
        end else if (grant_auto) begin
          state_d = S_STEP;
        end
      end
      S_STEP:     state_d = auto_step_q ? S_IDLE : S_ACK;
      S_WRITE:    state_d = S_ACK;
      S_RD_SETUP: state_d = S_RD_CAP;
      S_RD_CAP:   state_d = S_ACK;
      S_ACK:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs. Row address and write data are
  // captured straight from the host inputs in the grant cycle, so later
  // changes on those inputs cannot reach the grid.
  always_comb begin
    host_ack_d   = (state_d == S_ACK);
    life_en_d    = (state_d == S_STEP);
    life_wr_en_d = (state_d == S_WRITE);
    busy_d       = (state_d != S_IDLE);
    row_sel_d    = life_row_select;
    data_in_d    = life_data_in;
    rdata_d      = host_rdata;
    if (grant_host && ((host_op == OP_WRITE) || (host_op == OP_READ))) begin
      row_sel_d = host_row;
    end
    if (grant_host && (host_op == OP_WRITE)) begin
      data_in_d = host_wdata;
    end
    if (state_q == S_RD_CAP) begin
      rdata_d = life_data_out;
    end
  end

  // FSM state and grant bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      auto_step_q   <= 1'b0;
      prefer_auto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_host) begin
        auto_step_q   <= 1'b0;
        prefer_auto_q <= 1'b1;
      end else if (grant_auto) begin
        auto_step_q   <= 1'b1;
        prefer_auto_q <= 1'b0;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      host_ack        <= 1'b0;
      life_en         <= 1'b0;
      life_wr_en      <= 1'b0;
      busy            <= 1'b0;
      life_row_select <= '0;
      life_data_in    <= '0;
      host_rdata      <= '0;
    end else begin
      host_ack        <= host_ack_d;
      life_en         <= life_en_d;
      life_wr_en      <= life_wr_en_d;
      busy            <= busy_d;
      life_row_select <= row_sel_d;
      life_data_in    <= data_in_d;
      host_rdata      <= rdata_d;
    end
  end

  // Auto-step timer. A wrap always (re)arms the pending flag, even in the
  // cycle the previous pending step is granted; otherwise a grant clears it.
  always_ff @(posedge clk) begin
    if (rst || !auto_active) begin
      timer_q        <= '0;
      auto_pending_q <= 1'b0;
    end else if (timer_wrap) begin
      timer_q        <= '0;
      auto_pending_q <= 1'b1;
    end else begin
      timer_q        <= timer_q + CNT_W'(1);
      auto_pending_q <= auto_pending_q && !grant_auto;
    end
  end

`ifdef SILIFE_SCHED_STATS_EN
  // A wrap that finds the previous step still pending is a lost step.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count <= 8'd0;
    end else if (timer_wrap && auto_pending_q) begin
      miss_count <= sat_inc8(miss_count);
    end
  end
`endif

endmodule

// File: tb/tb_silife_sched.sv
module tb_silife_sched;

  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             host_req;
  logic [1:0]       host_op;
  logic [4:0]       host_row;
  logic [7:0]       host_wdata;
  logic             host_ack;
  logic [7:0]       host_rdata;
  logic             auto_en;
  logic [CNT_W-1:0] auto_period;
  logic [4:0]       life_row_select;
  logic             life_wr_en;
  logic             life_en;
  logic [7:0]       life_data_in;
  logic [7:0]       life_data_out;
  logic             busy;
`ifdef SILIFE_SCHED_STATS_EN
  logic [7:0]       miss_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  silife_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .host_req(host_req),
    .host_op(host_op),
    .host_row(host_row),
    .host_wdata(host_wdata),
    .host_ack(host_ack),
    .host_rdata(host_rdata),
    .auto_en(auto_en),
    .auto_period(auto_period),
    .life_row_select(life_row_select),
    .life_wr_en(life_wr_en),
    .life_en(life_en),
    .life_data_in(life_data_in),
    .life_data_out(life_data_out),
    .busy(busy)
`ifdef SILIFE_SCHED_STATS_EN
    ,
    .miss_count(miss_count)
`endif
  );

  // Simple stand-in for the life grid: 32 rows of 8 bits.
  logic [7:0] grid [32];
  assign life_data_out = grid[life_row_select];
  always @(posedge clk) begin
    if (life_wr_en) grid[life_row_select] <= life_data_in;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference model. Each grant schedules its visible
  // effects on a timeline of absolute cycle numbers.
  int         cyc = 0;
  bit         model_valid = 0;
  int         free_at, ack_at, rd_at;
  int         m_timer;
  bit         m_pend, m_pref_auto;
  logic [7:0] shadow [32];
  logic [7:0] rd_val;
  logic       e_en, e_wr, e_ack, e_busy;
  logic [4:0] e_row;
  logic [7:0] e_din, e_rdata;
  int         e_miss;

  always @(posedge clk) begin : model_b
    bit idle, g_host, g_auto, old_pend, active;
    int per;
    cyc++;
    if (rst) begin
      model_valid = 1;
      free_at = cyc; ack_at = -1; rd_at = -1;
      m_timer = 0; m_pend = 0; m_pref_auto = 0;
      e_en = 0; e_wr = 0; e_ack = 0; e_busy = 0;
      e_row = 0; e_din = 0; e_rdata = 0; e_miss = 0;
    end else if (model_valid) begin
      e_en = 0; e_wr = 0;
      e_ack = (cyc == ack_at);
      if (cyc == rd_at) e_rdata = rd_val;
      idle     = ((cyc - 1) >= free_at);
      old_pend = m_pend;
      g_host   = idle && host_req && !(m_pend && m_pref_auto);
      g_auto   = idle && m_pend && !g_host;
      if (g_host) begin
        m_pref_auto = 1;
        case (host_op)
          2'b00: begin e_en = 1; ack_at = cyc + 1; free_at = cyc + 2; end
          2'b01: begin
            e_wr = 1; e_row = host_row; e_din = host_wdata;
            shadow[host_row] = host_wdata;
            ack_at = cyc + 1; free_at = cyc + 2;
          end
          2'b10: begin
            e_row = host_row; rd_val = shadow[host_row];
            rd_at = cyc + 2; ack_at = cyc + 2; free_at = cyc + 3;
          end
          default: begin e_ack = 1; free_at = cyc + 1; end
        endcase
      end else if (g_auto) begin
        m_pref_auto = 0;
        e_en = 1;
        free_at = cyc + 1;
      end
      per = int'(auto_period);
      active = auto_en && (per != 0);
      if (!active) begin
        m_timer = 0; m_pend = 0;
      end else if (m_timer >= per - 1) begin
        if (old_pend && e_miss < 255) e_miss++;
        m_timer = 0; m_pend = 1;
      end else begin
        m_timer++;
        if (g_auto) m_pend = 0;
      end
      e_busy = (cyc < free_at);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (model_valid) begin
      check("life_en", 32'(life_en), 32'(e_en));
      check("life_wr_en", 32'(life_wr_en), 32'(e_wr));
      check("host_ack", 32'(host_ack), 32'(e_ack));
      check("busy", 32'(busy), 32'(e_busy));
      check("row_select", 32'(life_row_select), 32'(e_row));
      check("data_in", 32'(life_data_in), 32'(e_din));
      check("host_rdata", 32'(host_rdata), 32'(e_rdata));
      check("strobe_excl", 32'((life_en && life_wr_en) || (life_en && host_ack) ||
                               (life_wr_en && host_ack)), 32'(0));
`ifdef SILIFE_SCHED_STATS_EN
      check("miss_count", 32'(miss_count), 32'(e_miss));
`endif
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  int pulses [4];
  int np, acks, wait_cnt;

  initial begin
    for (int r = 0; r < 32; r++) begin
      grid[r] = 8'h00;
      shadow[r] = 8'h00;
    end
    rst = 1; host_req = 0; host_op = 2'b11; host_row = 0; host_wdata = 0;
    auto_en = 0; auto_period = '0;
    nclk(3);
    check("rst_ack", 32'(host_ack), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_en", 32'(life_en), 32'(0));
    check("rst_row", 32'(life_row_select), 32'(0));
    check("rst_rdata", 32'(host_rdata), 32'(0));
    rst = 0;

    // Write row 5 with A5; inputs are scrambled after the grant
    host_req = 1; host_op = 2'b01; host_row = 5; host_wdata = 8'hA5;
    nclk(1);
    check("wr_en_n1", 32'(life_wr_en), 32'(1));
    check("wr_row_n1", 32'(life_row_select), 32'(5));
    check("wr_data_n1", 32'(life_data_in), 32'hA5);
    host_op = 2'b00; host_row = 7; host_wdata = 8'h00;
    nclk(1);
    check("wr_ack_n2", 32'(host_ack), 32'(1));
    check("wr_en_n2", 32'(life_wr_en), 32'(0));
    host_req = 0;
    nclk(1);
    check("wr_idle_n3", 32'(busy), 32'(0));

    // Read row 5 back
    host_req = 1; host_op = 2'b10; host_row = 5;
    nclk(1);
    check("rd_row_n1", 32'(life_row_select), 32'(5));
    check("rd_ack_n1", 32'(host_ack), 32'(0));
    host_row = 3;
    nclk(1);
    check("rd_ack_n2", 32'(host_ack), 32'(0));
    nclk(1);
    check("rd_ack_n3", 32'(host_ack), 32'(1));
    check("rd_data_n3", 32'(host_rdata), 32'hA5);
    host_req = 0;
    nclk(1);

    // Tie between auto tick and host step right after reset
    rst = 1; nclk(2); rst = 0;
    auto_en = 1; auto_period = CNT_W'(6);
    nclk(6);
    host_req = 1; host_op = 2'b00;
    nclk(1);
    check("tie1_host_en", 32'(life_en), 32'(1));
    check("tie1_no_ack", 32'(host_ack), 32'(0));
    nclk(1);
    check("tie1_ack", 32'(host_ack), 32'(1));
    check("tie1_en_off", 32'(life_en), 32'(0));
    host_req = 0;
    nclk(1);
    check("tie1_idle", 32'(busy), 32'(0));
    nclk(1);
    check("auto_after_host_en", 32'(life_en), 32'(1));
    check("auto_no_ack", 32'(host_ack), 32'(0));
    nclk(1);
    check("auto_done_idle", 32'(busy), 32'(0));
    nclk(1);
    host_req = 1; host_op = 2'b00;
    nclk(1);
    check("tie2_host_en", 32'(life_en), 32'(1));
    nclk(1);
    check("tie2_host_ack", 32'(host_ack), 32'(1));
    host_req = 0; auto_en = 0;
    nclk(3);

    // Reset while capturing read data
    host_req = 1; host_op = 2'b10; host_row = 5;
    nclk(2);
    rst = 1; host_req = 0;
    nclk(1);
    check("abort_ack", 32'(host_ack), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_row", 32'(life_row_select), 32'(0));
    check("abort_rdata", 32'(host_rdata), 32'(0));
    check("abort_din", 32'(life_data_in), 32'(0));
    check("abort_strobes", 32'({life_en, life_wr_en}), 32'(0));
    rst = 0;

    // Free-running auto steps, period 10
    rst = 1; nclk(1); rst = 0;
    auto_en = 1; auto_period = CNT_W'(10);
    np = 0; acks = 0;
    for (int k = 1; k <= 80 && np < 4; k++) begin
      @(negedge clk);
      if (life_en) begin pulses[np] = k; np++; end
      if (host_ack) acks++;
    end
    check("auto_pulse_count", 32'(np), 32'(4));
    if (np == 4) begin
      check("auto_first_pulse", 32'(pulses[0]), 32'(11));
      for (int j = 1; j < 4; j++) check("auto_spacing", 32'(pulses[j] - pulses[j-1]), 32'(10));
    end
    check("auto_never_ack", 32'(acks), 32'(0));
    auto_en = 0;

    // Randomised traffic
    wait_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rst) rst = 0;
      else if ($urandom_range(0, 199) == 0) rst = 1;
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 49) == 0) auto_period = CNT_W'($urandom_range(0, 12));
      if (host_req) begin
        if (host_ack) begin
          host_req = 0; wait_cnt = 0;
        end else begin
          wait_cnt++;
          if (wait_cnt > 60) begin
            check("host_timeout", 32'(wait_cnt), 32'(0));
            host_req = 0; wait_cnt = 0;
          end
          if ($urandom_range(0, 3) == 0) begin
            host_op = 2'($urandom_range(0, 3));
            host_row = 5'($urandom_range(0, 31));
            host_wdata = 8'($urandom_range(0, 255));
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        host_req = 1;
        host_op = 2'($urandom_range(0, 3));
        host_row = 5'($urandom_range(0, 31));
        host_wdata = 8'($urandom_range(0, 255));
      end
    end
    host_req = 0; rst = 0;

    // Continuous reads against a period-2 auto-stepper
    @(negedge clk);
    rst = 1; nclk(1); rst = 0;
    auto_en = 1; auto_period = CNT_W'(2);
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (host_req && host_ack) host_req = 0;
      else if (!host_req) begin
        host_req = 1; host_op = 2'b10; host_row = 5'($urandom_range(0, 31));
      end
    end
`ifdef SILIFE_SCHED_STATS_EN
    check("miss_saturated", 32'(miss_count), 32'(255));
`endif
    host_req = 0; auto_en = 0;
    nclk(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
